key_debounce_ctrl: RTL and testbench
====================================

Name: key_debounce_ctrl

Overview:
- Avalon-MM slave controller for the push-button KEY inputs of the SoC.
- Synchronises and debounces each key, captures press events in a sticky edge-capture register and raises a maskable interrupt to the Nios II.
- Sits between the board KEY pins and the system interconnect, in place of a bare input PIO.
- Software polls the debounced level, or services presses through the IRQ.

Parameters:
- WIDTH, 4, number of key inputs (1..32).
- CNT_W, 20, width of the debounce counters and the period register.
- DB_DEFAULT, 50000, reset value of the debounce period in clk cycles (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- address  input  2  register word address
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe, qualified by chipselect
- writedata  input  32  write data
- readdata  output  32  registered read data
- in_port  input  WIDTH  raw KEY pins, active low (0 = pressed)
- irq  output  1  level interrupt, active high

Behaviour:
- Clock and reset: single clk domain. Reset is asynchronous, active-low (reset_n).
- Reset values:
  - readdata = 0, irq = 0
  - sync flops = all 1s, debounced level = all 1s (released)
  - edgecapture = 0, irqmask = 0, period = DB_DEFAULT
  - all key FSMs in REL
- Synchroniser: 2-flop synchroniser per bit on in_port. FSM input is the second flop.
- Per-key FSM (independent per bit):
  - Counter cnt[CNT_W-1:0].
  - States: REL (stable released), CHK_P (pending press), PRS (stable pressed), CHK_R (pending release).
  - REL: sync=0 -> CHK_P, cnt=0.
  - CHK_P: sync=1 -> REL (bounce rejected). Else cnt++. When cnt == eff_period-1 -> PRS, level bit <= 0, press pulse.
  - PRS: sync=1 -> CHK_R, cnt=0.
  - CHK_R: sync=0 -> PRS. Else cnt++. When cnt == eff_period-1 -> REL, level bit <= 1 (no event).
  - eff_period = max(period, 1). Period 0 is treated as 1.
- Latency: level changes (2 sync + eff_period + 1) cycles after a clean pin edge. The press pulse is asserted in the same cycle the level goes to 0.
- Period change mid-count: takes effect immediately. If cnt already ≥ new eff_period-1, transition on the next cycle.
- Register map (word address), all registers bits [WIDTH-1:0]:
  - 0 DATA (RO): debounced level, upper bits 0.
  - 1 IRQMASK (RW): writes ignored on upper bits.
  - 2 EDGECAP (R/W1C): bit set by press pulse; writing 1 clears that bit.
  - 3 PERIOD (RW): bits [CNT_W-1:0].
- Writes: occur when chipselect=1 and write_n=0. Writes to address 0 are ignored.
- Reads: readdata registered every cycle from the address mux, so it is valid 1 cycle after address. Unused bits read 0. Reads have no side effects.
- Simultaneous press pulse and W1C on the same bit: set wins, bit stays 1.
- irq: registered, irq <= |(edgecapture & irqmask). Asserted 1 cycle after the capture bit or mask sets. Deasserts 1 cycle after clear.
- Reset asserted mid-debounce: all state returns to reset values immediately. No event is generated on release of reset, even if a pin is held low. A held key is then debounced afresh and produces one press event.

Test Plan:
- Reset defaults: hold reset_n=0, in_port=4'hF, release. Read addr0 -> 0xF, addr1 -> 0, addr2 -> 0, addr3 -> 50000. irq=0.
- Clean press: set PERIOD=10, drive in_port[1]=0. addr0 reads 0xD exactly 13 cycles after the pin edge. EDGECAP reads 0x2. With IRQMASK=0x2, irq=1 one cycle later.
- Bounce rejection: PERIOD=10, toggle in_port[0] low for 9 cycles, high for 1, repeated 5 times. DATA stays 0xF, EDGECAP stays 0. Then hold low 20 cycles -> exactly one capture, EDGECAP=0x1.
- W1C and collision: EDGECAP=0x3, write 0x1 to addr2 -> reads 0x2, irq follows mask. Schedule a key0 press pulse in the same cycle as a W1C of bit0 -> bit0 remains 1.
- Release and period edge: release key -> DATA returns to 0xF after 2+PERIOD+1 cycles, no new capture. Write PERIOD=0 -> a 2-cycle low pulse is accepted as a press.
- Mid-operation reset: assert reset_n during CHK_P with in_port[2] held low. All registers return to defaults. After release, EDGECAP=0x4 after 2+DB_DEFAULT+1 cycles.

Source files
------------

// File: rtl/key_debounce_ctrl.sv
// Avalon-MM push-button controller. Each key is synchronised and debounced,
// and presses are latched in a sticky W1C capture register with a maskable IRQ.
module key_debounce_ctrl #(
    parameter int WIDTH      = 4,
    parameter int CNT_W      = 20,
    parameter int DB_DEFAULT = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    typedef enum logic [1:0] {
        REL   = 2'd0,
        CHK_P = 2'd1,
        PRS   = 2'd2,
        CHK_R = 2'd3
    } key_state_t;

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] level_r;
    logic [WIDTH-1:0] edgecap_r;
    logic [WIDTH-1:0] irqmask_r;
    logic [CNT_W-1:0] period_r;
    key_state_t       state_r [WIDTH];
    logic [CNT_W-1:0] cnt_r   [WIDTH];

    logic             wr_s;
    logic [CNT_W-1:0] eff_last_s;
    logic [WIDTH-1:0] press_s;
    logic [WIDTH-1:0] w1c_s;
    logic [31:0]      rd_mux_s;
    logic             unused_s;

    assign wr_s     = chipselect & ~write_n;
    assign unused_s = ^writedata;

    // Two-flop synchroniser; idles at released (1) so reset never looks like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= '1;
            sync2_r <= '1;
        end else begin
            sync1_r <= in_port;
            sync2_r <= sync1_r;
        end
    end

    // Last count value of a debounce window; a period of 0 behaves like 1.
    always_comb begin
        if (period_r == '0) begin
            eff_last_s = '0;
        end else begin
            eff_last_s = period_r - CNT_W'(1);
        end
    end

    // Press pulse fires on the same edge that the debounced level drops to 0.
    always_comb begin
        press_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (state_r[i] == CHK_P && !sync2_r[i] && cnt_r[i] >= eff_last_s) begin
                press_s[i] = 1'b1;
            end else begin
                press_s[i] = 1'b0;
            end
        end
    end

    // Per-key debounce FSMs; >= lets a shortened period complete a pending count at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_r[i] <= REL;
                cnt_r[i]   <= '0;
            end
            level_r <= '1;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                case (state_r[i])
                    REL: begin
                        if (!sync2_r[i]) begin
                            state_r[i] <= CHK_P;
                            cnt_r[i]   <= '0;
                        end
                    end
                    CHK_P: begin
                        if (sync2_r[i]) begin
                            state_r[i] <= REL;
                        end else if (cnt_r[i] >= eff_last_s) begin
                            state_r[i] <= PRS;
                            level_r[i] <= 1'b0;
                        end else begin
                            cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                        end
                    end
                    PRS: begin
                        if (sync2_r[i]) begin
                            state_r[i] <= CHK_R;
                            cnt_r[i]   <= '0;
                        end
                    end
                    CHK_R: begin
                        if (!sync2_r[i]) begin
                            state_r[i] <= PRS;
                        end else if (cnt_r[i] >= eff_last_s) begin
                            state_r[i] <= REL;
                            level_r[i] <= 1'b1;
                        end else begin
                            cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_r[i] <= REL;
                        cnt_r[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Write-one-to-clear mask for the capture register.
    always_comb begin
        if (wr_s && address == 2'd2) begin
            w1c_s = writedata[WIDTH-1:0];
        end else begin
            w1c_s = '0;
        end
    end

    // Read mux; unused upper bits stay zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            2'd0:    rd_mux_s[WIDTH-1:0] = level_r;
            2'd1:    rd_mux_s[WIDTH-1:0] = irqmask_r;
            2'd2:    rd_mux_s[WIDTH-1:0] = edgecap_r;
            2'd3:    rd_mux_s[CNT_W-1:0] = period_r;
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Register file, registered read data and interrupt; a press beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap_r <= '0;
            irqmask_r <= '0;
            period_r  <= CNT_W'(DB_DEFAULT);
            readdata  <= 32'd0;
            irq       <= 1'b0;
        end else begin
            edgecap_r <= (edgecap_r & ~w1c_s) | press_s;
            if (wr_s && address == 2'd1) begin
                irqmask_r <= writedata[WIDTH-1:0];
            end
            if (wr_s && address == 2'd3) begin
                period_r <= writedata[CNT_W-1:0];
            end
            readdata <= rd_mux_s;
            irq      <= |(edgecap_r & irqmask_r);
        end
    end

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Self-checking bench for key_debounce_ctrl: directed scenarios plus random
// traffic, compared every cycle against a run-length reference model.
module tb_key_debounce_ctrl;

    localparam int W      = 4;
    localparam int DB_DEF = 50000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [3:0]  in_port = 4'hF;
    logic        irq;

    int errors = 0;
    int checks = 0;

    // Reference model: pins reach the debouncer two cycles late; a key flips once it
    // has seen (effective period + 1) consecutive samples opposite to its level.
    logic [3:0]  m_p1, m_p2, m_lvl, m_ec, m_mask;
    int          m_run [4];
    int unsigned m_per;
    logic [31:0] m_rd;
    logic        m_irq;

    key_debounce_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_p1 = 4'hF; m_p2 = 4'hF; m_lvl = 4'hF;
        m_ec = 4'h0; m_mask = 4'h0; m_per = DB_DEF;
        m_rd = 32'd0; m_irq = 1'b0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    task automatic tick();
        logic [3:0]  pins = in_port;
        logic        wr = chipselect && !write_n;
        logic [1:0]  a = address;
        logic [31:0] wd = writedata;
        logic [3:0]  press = 4'h0;
        logic [3:0]  lvl_n;
        logic [31:0] rd_n;
        logic        irq_n;
        int          eff;
        @(posedge clk);
        #1;
        case (a)
            2'd0:    rd_n = {28'd0, m_lvl};
            2'd1:    rd_n = {28'd0, m_mask};
            2'd2:    rd_n = {28'd0, m_ec};
            default: rd_n = m_per;
        endcase
        irq_n = |(m_ec & m_mask);
        eff   = (m_per == 0) ? 1 : int'(m_per);
        lvl_n = m_lvl;
        for (int i = 0; i < W; i++) begin
            if (m_p2[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] >= eff + 1) begin
                    lvl_n[i] = m_p2[i];
                    if (!m_p2[i]) press[i] = 1'b1;
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_ec = (m_ec & ~((wr && a == 2'd2) ? wd[3:0] : 4'h0)) | press;
        if (wr && a == 2'd1) m_mask = wd[3:0];
        if (wr && a == 2'd3) m_per = {12'd0, wd[19:0]};
        m_lvl = lvl_n;
        m_p2  = m_p1;
        m_p1  = pins;
        m_rd  = rd_n;
        m_irq = irq_n;
        check("model_rd", readdata, m_rd);
        check("model_irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        tick();
        check(tag, readdata, exp);
    endtask

    initial begin
        // Reset defaults
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd", readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd0, 32'hF, "rst_data");
        rd(2'd1, 32'h0, "rst_mask");
        rd(2'd2, 32'h0, "rst_cap");
        rd(2'd3, 32'd50000, "rst_period");
        check("rst_irq2", {31'd0, irq}, 32'd0);

        // Clean press on key1 with PERIOD=10: level drops 13 cycles after the pin edge
        wr(2'd3, 32'd10);
        address = 2'd0;
        in_port = 4'hD;
        wait_n(13);
        check("press_pre", readdata, 32'hF);
        tick();
        check("press_data", readdata, 32'hD);
        rd(2'd2, 32'h2, "press_cap");
        wr(2'd1, 32'h2);
        check("irq_pre", {31'd0, irq}, 32'd0);
        tick();
        check("irq_set", {31'd0, irq}, 32'd1);

        // Bounce rejection on key0
        in_port = 4'hF;
        wait_n(20);
        wr(2'd2, 32'hF);
        repeat (5) begin
            in_port = 4'hE; wait_n(9);
            in_port = 4'hF; wait_n(1);
        end
        rd(2'd0, 32'hF, "bounce_data");
        rd(2'd2, 32'h0, "bounce_cap");
        in_port = 4'hE;
        wait_n(20);
        rd(2'd0, 32'hE, "hold_data");
        rd(2'd2, 32'h1, "hold_cap");

        // W1C, irq following the mask, and press/clear collision
        in_port = 4'hC;
        wait_n(20);
        rd(2'd2, 32'h3, "cap_both");
        wr(2'd2, 32'h1);
        rd(2'd2, 32'h2, "w1c");
        check("irq_follow", {31'd0, irq}, 32'd1);
        wr(2'd1, 32'h0);
        tick();
        check("irq_masked", {31'd0, irq}, 32'd0);
        in_port = 4'hF;
        wait_n(20);
        wr(2'd2, 32'h3);
        in_port = 4'hE;
        wait_n(12);
        wr(2'd2, 32'h1);
        rd(2'd2, 32'h1, "collision");

        // Release timing, then PERIOD=0 accepts a 2-cycle pulse
        address = 2'd0;
        in_port = 4'hF;
        wait_n(13);
        check("rel_pre", readdata, 32'hE);
        tick();
        check("rel_data", readdata, 32'hF);
        rd(2'd2, 32'h1, "rel_nocap");
        wr(2'd3, 32'd0);
        wr(2'd2, 32'hF);
        in_port = 4'h7;
        wait_n(2);
        in_port = 4'hF;
        wait_n(10);
        rd(2'd2, 32'h8, "short_press");
        rd(2'd3, 32'h0, "period_zero");

        // Random traffic against the model
        wr(2'd1, 32'hF);
        repeat (300) begin
            in_port = 4'($urandom);
            address = 2'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                logic [1:0]  wa = 2'($urandom);
                logic [31:0] wd = $urandom;
                if (wa == 2'd3) wd = (wd & 32'hFFF0_0000) | $urandom_range(0, 6);
                wr(wa, wd);
            end
            wait_n($urandom_range(1, 8));
        end

        // Reset in the middle of a pending press on key2
        wr(2'd3, 32'd100);
        in_port = 4'hB;
        wait_n(10);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_rd", readdata, 32'd0);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd0, 32'hF, "mid_rst_data");
        rd(2'd1, 32'h0, "mid_rst_mask");
        rd(2'd2, 32'h0, "mid_rst_cap");
        rd(2'd3, 32'd50000, "mid_rst_period");
        address = 2'd2;
        wait_n(DB_DEF - 1);
        check("rst_cap_pre", readdata, 32'h0);
        tick();
        check("rst_cap", readdata, 32'h4);
        rd(2'd0, 32'hB, "rst_hold_data");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
